// File: rtl/tri_edge_sequencer.sv
// tri_edge_sequencer: takes one triangle, sorts it via an external sorter,
// then serialises its three edges onto a single shared edge-draw engine.
module tri_edge_sequencer #(
  parameter int W       = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic         c,
  input  logic         rn,
  input  logic         tri_v,
  output logic         tri_r,
  input  logic [W-1:0] v1x, v1y, v1z,
  input  logic [W-1:0] v2x, v2y, v2z,
  input  logic [W-1:0] v3x, v3y, v3z,
  output logic [W-1:0] p1x, p1y, p1z,
  output logic [W-1:0] p2x, p2y, p2z,
  output logic [W-1:0] p3x, p3y, p3z,
  output logic         se,
  input  logic [W-1:0] s1x, s1y, s1z,
  input  logic [W-1:0] s2x, s2y, s2z,
  input  logic [W-1:0] s3x, s3y, s3z,
  output logic         es,
  output logic [W-1:0] ex0, ey0, ez0,
  output logic [W-1:0] ex1, ey1, ez1,
  output logic [1:0]   ei,
  input  logic         ed,
  output logic         busy,
  output logic         tri_done,
  output logic         err
);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } vtx_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SORT, S_SETL,
    S_CHECK, S_BUSY, S_DONE
  } state_t;

  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  vtx_t          p1_q, p2_q, p3_q, p1_d, p2_d, p3_d;
  vtx_t          s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  vtx_t          ea_q, eb_q, ea_d, eb_d;
  vtx_t          a, b;
  logic [1:0]    ei_q, ei_d;
  logic          es_q, es_d, se_q, se_d;
  logic          busy_q, busy_d, tr_q, tr_d;
  logic          dn_q, dn_d, err_q, err_d;

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      ei_q    <= '0;
      es_q    <= 1'b0;
      se_q    <= 1'b0;
      busy_q  <= 1'b0;
      tr_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      ei_q    <= ei_d;
      es_q    <= es_d;
      se_q    <= se_d;
      busy_q  <= busy_d;
      tr_q    <= tr_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
    end
  end

  // Endpoint pair for the current edge index
  always_comb begin
    a = s1_q;
    b = s2_q;
    unique case (1'b1)
      (ei_q == 2'd0): begin a = s1_q; b = s2_q; end
      (ei_q == 2'd1): begin a = s1_q; b = s3_q; end
      default:        begin a = s2_q; b = s3_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    ei_d    = ei_q;
    err_d   = err_q;
    es_d    = 1'b0;
    se_d    = 1'b0;
    tr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tr_d = 1'b1;
        if (tri_v && tr_q) begin
          p1_d    = '{v1x, v1y, v1z};
          p2_d    = '{v2x, v2y, v2z};
          p3_d    = '{v3x, v3y, v3z};
          err_d   = 1'b0;
          tr_d    = 1'b0;
          se_d    = 1'b1;
          state_d = S_SORT;
        end
      end
      S_SORT: begin
        cnt_d   = '0;
        state_d = S_SETL;
      end
      S_SETL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_LAST) begin
          s1_d    = '{s1x, s1y, s1z};
          s2_d    = '{s2x, s2y, s2z};
          s3_d    = '{s3x, s3y, s3z};
          ei_d    = 2'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (a == b) begin
          if (ei_q == 2'd2) state_d = S_DONE;
          else ei_d = ei_q + 2'd1;
        end else begin
          ea_d    = a;
          eb_d    = b;
          es_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // done beats a coincident timeout
        if (ed) begin
          if (ei_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            ei_d    = ei_q + 2'd1;
            state_d = S_CHECK;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        tr_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    dn_d   = (state_d == S_DONE);
  end

  assign tri_r    = tr_q;
  assign se       = se_q;
  assign es       = es_q;
  assign ei       = ei_q;
  assign busy     = busy_q;
  assign tri_done = dn_q;
  assign err      = err_q;
  assign {p1x, p1y, p1z} = p1_q;
  assign {p2x, p2y, p2z} = p2_q;
  assign {p3x, p3y, p3z} = p3_q;
  assign {ex0, ey0, ez0} = ea_q;
  assign {ex1, ey1, ez1} = eb_q;

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// tb_tri_edge_sequencer: directed scenarios with a behavioural
// x-sorter and a delayed-done edge engine model.
module tb_tri_edge_sequencer;
  logic c = 1'b0;
  logic rn, tri_v, tri_r, se, es, ed;
  logic busy, tri_done, err;
  logic [1:0] ei;
  logic [3:0] v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;
  logic [3:0] p1x, p1y, p1z, p2x, p2y, p2z, p3x, p3y, p3z;
  logic [3:0] s1x, s1y, s1z, s2x, s2y, s2z, s3x, s3y, s3z;
  logic [3:0] ex0, ey0, ez0, ex1, ey1, ez1;

  logic ed_resp = 1'b0;
  logic ed_force = 1'b0;
  bit   resp_en = 1'b1;
  int   resp_dly = 3;
  int   cd = 0;
  assign ed = ed_resp | ed_force;

  int npass = 0;
  int ntot = 0;
  int cyc = 0;
  int a0 = 0;
  int se_cnt = 0, se_rel = 0;
  int done_cnt = 0, done_rel = 0;
  int acc_cnt = 0;
  int es_rel[$];
  logic [1:0] es_ei[$];
  logic [23:0] es_ep[$];
  logic [11:0] q0, q1, q2, qt;

  tri_edge_sequencer dut (
    .c(c), .rn(rn), .tri_v(tri_v), .tri_r(tri_r),
    .v1x(v1x), .v1y(v1y), .v1z(v1z),
    .v2x(v2x), .v2y(v2y), .v2z(v2z),
    .v3x(v3x), .v3y(v3y), .v3z(v3z),
    .p1x(p1x), .p1y(p1y), .p1z(p1z),
    .p2x(p2x), .p2y(p2y), .p2z(p2z),
    .p3x(p3x), .p3y(p3y), .p3z(p3z),
    .se(se),
    .s1x(s1x), .s1y(s1y), .s1z(s1z),
    .s2x(s2x), .s2y(s2y), .s2z(s2z),
    .s3x(s3x), .s3y(s3y), .s3z(s3z),
    .es(es),
    .ex0(ex0), .ey0(ey0), .ez0(ez0),
    .ex1(ex1), .ey1(ey1), .ez1(ez1),
    .ei(ei), .ed(ed), .busy(busy),
    .tri_done(tri_done), .err(err)
  );

  initial forever #5 c = ~c;

  always @(posedge c) cyc = cyc + 1;

  // sorter: ascending x, stable on ties
  always @(negedge c) begin
    if (se) begin
      q0 = {p1x, p1y, p1z};
      q1 = {p2x, p2y, p2z};
      q2 = {p3x, p3y, p3z};
      if (q0[11:8] > q1[11:8]) begin qt = q0; q0 = q1; q1 = qt; end
      if (q1[11:8] > q2[11:8]) begin qt = q1; q1 = q2; q2 = qt; end
      if (q0[11:8] > q1[11:8]) begin qt = q0; q0 = q1; q1 = qt; end
      {s1x, s1y, s1z} = q0;
      {s2x, s2y, s2z} = q1;
      {s3x, s3y, s3z} = q2;
    end
  end

  // edge engine: ed pulse resp_dly cycles after es
  always @(negedge c) begin
    ed_resp = 1'b0;
    if (!rn) cd = 0;
    else if (es && resp_en) cd = resp_dly;
    else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) ed_resp = 1'b1;
    end
  end

  // event log relative to the accept edge (cycle 1 = just after it)
  always @(negedge c) begin
    if (rn) begin
      if (tri_v && tri_r) begin
        a0 = cyc + 1;
        es_rel.delete();
        es_ei.delete();
        es_ep.delete();
        se_cnt = 0;
        done_cnt = 0;
        acc_cnt = acc_cnt + 1;
      end else begin
        if (se) begin se_cnt = se_cnt + 1; se_rel = cyc - a0 + 1; end
        if (es) begin
          es_rel.push_back(cyc - a0 + 1);
          es_ei.push_back(ei);
          es_ep.push_back({ex0, ey0, ez0, ex1, ey1, ez1});
        end
        if (tri_done) begin
          done_cnt = done_cnt + 1;
          done_rel = cyc - a0 + 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic set_v(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] d);
    {v1x, v1y, v1z} = a;
    {v2x, v2y, v2z} = b;
    {v3x, v3y, v3z} = d;
  endtask

  task automatic start_tri(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] d, input bit hold,
                           output bit acc);
    acc = 1'b0;
    set_v(a, b, d);
    tri_v = 1'b1;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(posedge c); #1;
      if (busy) acc = 1'b1;
    end
    if (!hold) tri_v = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(posedge c); #1;
      if (tri_done) begin got = 1'b1; tri_v = 1'b0; end
    end
    @(posedge c); #1;
  endtask

  task automatic test_reset;
    rn = 1'b0;
    tri_v = 1'b1;
    ed_force = 1'b0;
    set_v(12'h510, 12'h230, 12'h940);
    #22;
    ntot++;
    if ({tri_r, busy, se, es, tri_done, err, ei} !== 8'h00)
      $display("FAIL reset_ctl: got %h want 00",
               {tri_r, busy, se, es, tri_done, err, ei});
    else npass++;
    ntot++;
    if ({p1x, p1y, p1z, p2x, p2y, p2z, p3x, p3y, p3z, ex0, ey0, ez0,
         ex1, ey1, ez1} !== 60'h0)
      $display("FAIL reset_data: p/ex not zero");
    else npass++;
    @(negedge c);
    rn = 1'b1;
    @(posedge c); #1;
    ntot++;
    if ({tri_r, busy} !== 2'b10)
      $display("FAIL reset_release: got tri_r/busy %b want 10",
               {tri_r, busy});
    else npass++;
    tri_v = 1'b0;
    @(posedge c); #1;
  endtask

  task automatic test_nominal;
    bit acc, got;
    int acc0;
    logic [23:0] ep_exp[3];
    int rel_exp[3];
    ep_exp[0] = 24'h230510;
    ep_exp[1] = 24'h230940;
    ep_exp[2] = 24'h510940;
    rel_exp[0] = 5; rel_exp[1] = 10; rel_exp[2] = 15;
    acc0 = acc_cnt;
    start_tri(12'h510, 12'h230, 12'h940, 1'b1, acc);
    set_v(12'hfff, 12'heee, 12'hddd);
    wait_done(40, got);
    ntot++;
    if ({acc, got} !== 2'b11)
      $display("FAIL nom_handshake: acc/done %b want 11", {acc, got});
    else npass++;
    ntot++;
    if (acc_cnt - acc0 !== 1)
      $display("FAIL nom_single_accept: got %0d want 1", acc_cnt - acc0);
    else npass++;
    ntot++;
    if (se_cnt !== 1 || se_rel !== 1)
      $display("FAIL nom_se: cnt %0d cyc %0d want 1/1", se_cnt, se_rel);
    else npass++;
    ntot++;
    if (es_rel.size() !== 3)
      $display("FAIL nom_es_count: got %0d want 3", es_rel.size());
    else npass++;
    for (int i = 0; i < es_rel.size() && i < 3; i++) begin
      ntot++;
      if (es_rel[i] !== rel_exp[i] || es_ei[i] !== 2'(i) ||
          es_ep[i] !== ep_exp[i])
        $display("FAIL nom_edge%0d: cyc %0d ei %0d ep %h want %0d %0d %h",
                 i, es_rel[i], es_ei[i], es_ep[i], rel_exp[i], i,
                 ep_exp[i]);
      else npass++;
    end
    ntot++;
    if (done_cnt !== 1 || done_rel !== 19 || err !== 1'b0)
      $display("FAIL nom_done: cnt %0d cyc %0d err %b want 1 19 0",
               done_cnt, done_rel, err);
    else npass++;
    ntot++;
    if ({p1x, p1y, p1z, p2x, p2y, p2z, p3x, p3y, p3z} !== 36'h510230940)
      $display("FAIL nom_capture: got %h want 510230940",
               {p1x, p1y, p1z, p2x, p2y, p2z, p3x, p3y, p3z});
    else npass++;
    ntot++;
    if ({tri_r, busy} !== 2'b10)
      $display("FAIL nom_idle: tri_r/busy %b want 10", {tri_r, busy});
    else npass++;
  endtask

  task automatic test_degenerate_one;
    bit acc, got;
    start_tri(12'h700, 12'h444, 12'h444, 1'b0, acc);
    wait_done(40, got);
    ntot++;
    if ({acc, got} !== 2'b11)
      $display("FAIL deg1_handshake: acc/done %b want 11", {acc, got});
    else npass++;
    ntot++;
    if (es_rel.size() !== 2)
      $display("FAIL deg1_es_count: got %0d want 2", es_rel.size());
    else npass++;
    if (es_rel.size() == 2) begin
      ntot++;
      if (es_ei[0] !== 2'd1 || es_rel[0] !== 6 || es_ep[0] !== 24'h444700)
        $display("FAIL deg1_edge_a: ei %0d cyc %0d ep %h want 1 6 444700",
                 es_ei[0], es_rel[0], es_ep[0]);
      else npass++;
      ntot++;
      if (es_ei[1] !== 2'd2 || es_rel[1] !== 11 || es_ep[1] !== 24'h444700)
        $display("FAIL deg1_edge_b: ei %0d cyc %0d ep %h want 2 11 444700",
                 es_ei[1], es_rel[1], es_ep[1]);
      else npass++;
    end
    ntot++;
    if (done_cnt !== 1 || done_rel !== 15)
      $display("FAIL deg1_done: cnt %0d cyc %0d want 1 15",
               done_cnt, done_rel);
    else npass++;
  endtask

  task automatic test_degenerate_all;
    bit acc, got;
    start_tri(12'h333, 12'h333, 12'h333, 1'b0, acc);
    wait_done(40, got);
    ntot++;
    if ({acc, got} !== 2'b11)
      $display("FAIL deg3_handshake: acc/done %b want 11", {acc, got});
    else npass++;
    ntot++;
    if (es_rel.size() !== 0 || done_cnt !== 1 || done_rel !== 7 ||
        err !== 1'b0)
      $display("FAIL deg3_result: es %0d done %0d cyc %0d err %b want 0 1 7 0",
               es_rel.size(), done_cnt, done_rel, err);
    else npass++;
  endtask

  task automatic test_timeout;
    bit acc, got;
    resp_en = 1'b0;
    start_tri(12'h510, 12'h230, 12'h940, 1'b0, acc);
    wait_done(100, got);
    ntot++;
    if ({acc, got} !== 2'b11)
      $display("FAIL to_handshake: acc/done %b want 11", {acc, got});
    else npass++;
    ntot++;
    if (es_rel.size() !== 1 || done_cnt !== 1 || done_rel !== 69)
      $display("FAIL to_result: es %0d done %0d cyc %0d want 1 1 69",
               es_rel.size(), done_cnt, done_rel);
    else npass++;
    repeat (3) @(posedge c);
    #1;
    ntot++;
    if ({err, busy, tri_r} !== 3'b101)
      $display("FAIL to_err_sticky: err/busy/tri_r %b want 101",
               {err, busy, tri_r});
    else npass++;
    resp_en = 1'b1;
    set_v(12'h333, 12'h333, 12'h333);
    tri_v = 1'b1;
    @(posedge c); #1;
    tri_v = 1'b0;
    ntot++;
    if ({busy, err} !== 2'b10)
      $display("FAIL to_err_clear: busy/err %b want 10", {busy, err});
    else npass++;
    wait_done(40, got);
    ntot++;
    if (got !== 1'b1 || err !== 1'b0)
      $display("FAIL to_next_tri: done %b err %b want 1 0", got, err);
    else npass++;
  endtask

  task automatic test_done_vs_timeout;
    bit acc, got;
    resp_dly = 63;
    start_tri(12'h510, 12'h230, 12'h940, 1'b0, acc);
    wait_done(250, got);
    resp_dly = 3;
    ntot++;
    if ({acc, got} !== 2'b11)
      $display("FAIL tie_handshake: acc/done %b want 11", {acc, got});
    else npass++;
    ntot++;
    if (es_rel.size() !== 3 || done_rel !== 199 || err !== 1'b0)
      $display("FAIL tie_result: es %0d cyc %0d err %b want 3 199 0",
               es_rel.size(), done_rel, err);
    else npass++;
    if (es_rel.size() == 3) begin
      ntot++;
      if (es_rel[1] !== 70 || es_rel[2] !== 135)
        $display("FAIL tie_es_cycles: %0d %0d want 70 135",
                 es_rel[1], es_rel[2]);
      else npass++;
    end
  endtask

  task automatic test_reset_mid_busy;
    bit acc, hit;
    hit = 1'b0;
    start_tri(12'h510, 12'h230, 12'h940, 1'b0, acc);
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge c); #1;
      if (es && ei == 2'd1) hit = 1'b1;
    end
    ntot++;
    if (hit !== 1'b1)
      $display("FAIL rst_mid_reach: ei=1 es seen %b want 1", hit);
    else npass++;
    #2 rn = 1'b0;
    #1;
    ntot++;
    if ({es, se, busy, tri_done, tri_r, ei} !== 7'h00 ||
        {ex0, ey0, ez0, ex1, ey1, ez1} !== 24'h0)
      $display("FAIL rst_mid_async: ctl %h ep %h want 00 000000",
               {es, se, busy, tri_done, tri_r, ei},
               {ex0, ey0, ez0, ex1, ey1, ez1});
    else npass++;
    resp_en = 1'b0;
    @(negedge c);
    rn = 1'b1;
    @(posedge c); #1;
    ntot++;
    if ({tri_r, busy} !== 2'b10)
      $display("FAIL rst_mid_release: tri_r/busy %b want 10",
               {tri_r, busy});
    else npass++;
    ed_force = 1'b1;
    @(posedge c); #1;
    ed_force = 1'b0;
    @(posedge c); #1;
    ntot++;
    if ({tri_r, busy, es, ei, err} !== 6'b100000)
      $display("FAIL rst_mid_late_ed: got %b want 100000",
               {tri_r, busy, es, ei, err});
    else npass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_degenerate_one();
    test_degenerate_all();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
